// File: rtl/apd_overcurrent_guard.sv
// APD bias overcurrent guard: synchronizes and filters the raw comparator,
// drops bias on a confirmed fault, retries after a cooldown, and locks out
// after repeated trips until software clears it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARMED    | bias on, filter watching the synchronized comparator
//   COOLDOWN | bias off, timer running down before the automatic re-arm
//   LOCKOUT  | bias off, waits for clear with the comparator low
module apd_overcurrent_guard #(
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_LEN      = 16,
    parameter int COOLDOWN_CYCLES = 50000,
    parameter int MAX_RETRIES     = 3,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             comp_in,
    input  logic             clear,
    output logic             bias_en,
    output logic             overcurrent,
    output logic             lockout,
    output logic [CNT_W-1:0] trip_count
);

    // The filter counter never holds FILTER_LEN itself: it zeroes on the trip sample.
    localparam int FILT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam int TMR_W  = $clog2(COOLDOWN_CYCLES);
    localparam int RTR_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FILT_W-1:0]      filt_q, filt_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [RTR_W-1:0]       retry_q, retry_d;
    logic [CNT_W-1:0]       tc_d;
    logic                   oc_d;
    logic                   fault;

    assign s     = sync_q[SYNC_STAGES-1];
    assign fault = (state_q == ST_ARMED) && s && (filt_q == FILT_W'(FILTER_LEN - 1));

    // Comparator synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
    end

    // Next state, counters and sticky flags; clear is applied first so a
    // simultaneous fault still registers its trip on top of the cleared values.
    always_comb begin
        state_d = state_q;
        retry_d = clear ? '0 : retry_q;
        tc_d    = clear ? '0 : trip_count;
        oc_d    = clear ? 1'b0 : overcurrent;
        filt_d  = '0;
        tmr_d   = tmr_q;

        case (state_q)
            ST_ARMED: begin
                if (fault) begin
                    oc_d = 1'b1;
                    if (tc_d != '1) tc_d = tc_d + 1'b1;
                    if (retry_d == RTR_W'(MAX_RETRIES)) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        state_d = ST_COOLDOWN;
                        retry_d = retry_d + 1'b1;
                        tmr_d   = TMR_W'(COOLDOWN_CYCLES - 1);
                    end
                end else if (s) begin
                    filt_d = filt_q + 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (tmr_q == '0) state_d = ST_ARMED;
                else             tmr_d   = tmr_q - 1'b1;
            end
            ST_LOCKOUT: begin
                if (clear && !s) state_d = ST_ARMED;
            end
            default: state_d = ST_ARMED;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ARMED;
            filt_q      <= '0;
            tmr_q       <= '0;
            retry_q     <= '0;
            trip_count  <= '0;
            overcurrent <= 1'b0;
            bias_en     <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            filt_q      <= filt_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            trip_count  <= tc_d;
            overcurrent <= oc_d;
            bias_en     <= (state_d == ST_ARMED);
            lockout     <= (state_d == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_apd_overcurrent_guard.sv
// Directed bench for apd_overcurrent_guard with a short filter and cooldown.
// Outputs are compared as one vector {bias_en, overcurrent, lockout, trip_count}.
module tb_apd_overcurrent_guard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       comp_in;
    logic       clear;
    logic       bias_en;
    logic       overcurrent;
    logic       lockout;
    logic [7:0] trip_count;

    int n_total = 0;
    int n_pass  = 0;

    apd_overcurrent_guard #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .COOLDOWN_CYCLES(10),
        .MAX_RETRIES(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .comp_in(comp_in),
        .clear(clear),
        .bias_en(bias_en),
        .overcurrent(overcurrent),
        .lockout(lockout),
        .trip_count(trip_count)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        reset_n = 1'b0;
        comp_in = 1'b0;
        clear   = 1'b0;
        step(3);
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset_hold got=%h exp=%h", obs, {1'b0, 1'b0, 1'b0, 8'd0});
        else n_pass++;
        reset_n = 1'b1;
        step();
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset_release got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'd0});
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [10:0] obs;
        for (int r = 0; r < 5; r++) begin
            comp_in = 1'b1;
            step(3);
            comp_in = 1'b0;
            step(3);
            obs = {bias_en, overcurrent, lockout, trip_count};
            n_total++;
            if (obs !== {1'b1, 1'b0, 1'b0, 8'd0})
                $display("FAIL glitch_%0d got=%h exp=%h", r, obs, {1'b1, 1'b0, 1'b0, 8'd0});
            else n_pass++;
        end
    endtask

    task automatic test_single_trip();
        logic [10:0] obs;
        comp_in = 1'b1;
        step();                 // E0
        step(3);                // E0+3
        comp_in = 1'b0;
        step();                 // E0+4: one sample short of the trip
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL trip_pre got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'd0});
        else n_pass++;
        step();                 // E0+5
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 8'd1})
            $display("FAIL trip_edge got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 8'd1});
        else n_pass++;
        step(9);                // E0+14: still cooling down
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 8'd1})
            $display("FAIL cooldown_end_minus1 got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 8'd1});
        else n_pass++;
        step();                 // E0+15
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'd1})
            $display("FAIL cooldown_rearm got=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 8'd1});
        else n_pass++;
        pulse_clear();
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL clear_armed got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'd0});
        else n_pass++;
    endtask

    task automatic test_lockout();
        logic [10:0] obs;
        comp_in = 1'b1;
        step();                 // E0
        step(5);                // E0+5: trip 1
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 8'd1})
            $display("FAIL hold_trip1 got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 8'd1});
        else n_pass++;
        step(10);               // E0+15: re-armed while still high
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'd1})
            $display("FAIL hold_rearm1 got=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 8'd1});
        else n_pass++;
        step(4);                // E0+19: trip 2
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 8'd2})
            $display("FAIL hold_trip2 got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 8'd2});
        else n_pass++;
        step(10);               // E0+29
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'd2})
            $display("FAIL hold_rearm2 got=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 8'd2});
        else n_pass++;
        step(4);                // E0+33: trip 3 goes to lockout
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 8'd3})
            $display("FAIL hold_trip3 got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 8'd3});
        else n_pass++;
        step(15);
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 8'd3})
            $display("FAIL lockout_stays got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 8'd3});
        else n_pass++;
    endtask

    task automatic test_lockout_exit();
        logic [10:0] obs;
        pulse_clear();          // comparator still high
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd0})
            $display("FAIL clear_high got=%h exp=%h", obs, {1'b0, 1'b0, 1'b1, 8'd0});
        else n_pass++;
        comp_in = 1'b0;
        step(3);
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b0, 1'b1, 8'd0})
            $display("FAIL lockout_no_clear got=%h exp=%h", obs, {1'b0, 1'b0, 1'b1, 8'd0});
        else n_pass++;
        pulse_clear();
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL lockout_exit got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'd0});
        else n_pass++;
    endtask

    task automatic test_clear_on_fault_and_reset();
        logic [10:0] obs;
        comp_in = 1'b1;
        step();                 // E0
        step(4);                // E0+4
        clear = 1'b1;
        step();                 // E0+5: fault and clear on the same edge
        clear = 1'b0;
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 8'd1})
            $display("FAIL clear_vs_fault got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 8'd1});
        else n_pass++;
        step(3);                // mid-cooldown
        reset_n = 1'b0;
        #1;
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 8'd0})
            $display("FAIL async_reset got=%h exp=%h", obs, {1'b0, 1'b0, 1'b0, 8'd0});
        else n_pass++;
        comp_in = 1'b0;
        step(2);
        reset_n = 1'b1;
        step();
        obs = {bias_en, overcurrent, lockout, trip_count};
        n_total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL post_reset got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'd0});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_trip();
        test_lockout();
        test_lockout_exit();
        test_clear_on_fault_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apd_overcurrent_guard.md
# apd_overcurrent_guard

Protection stage for the APD bias supply. It synchronizes and filters the raw overcurrent comparator and removes APD bias on a confirmed fault. It then retries bias after a cooldown and locks out after repeated trips. Its sticky `overcurrent` output is the level the Avalon PIO input port presents to software; `clear` is a one-cycle pulse from a software-writable control bit.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on `comp_in` (≥2).
- FILTER_LEN, 16: consecutive synchronized-high samples required to trip (≥1).
- COOLDOWN_CYCLES, 50000: bias-off time after a trip (≥2).
- MAX_RETRIES, 3: automatic re-arms allowed before lockout.
- CNT_W, 8: width of `trip_count`.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- comp_in  in  1  raw comparator output, asynchronous to clk, high = overcurrent.
- clear  in  1  one-cycle pulse: acknowledge fault, reset counters, exit lockout.
- bias_en  out  1  APD bias enable, high = bias applied.
- overcurrent  out  1  sticky fault flag to the PIO input port.
- lockout  out  1  high while in LOCKOUT.
- trip_count  out  CNT_W  trips since last clear, saturating.

## Operation
- Synchronizer: `comp_in` passes through SYNC_STAGES flops; the last stage output is `s`.
- Filter counter: in ARMED it increments on each edge with `s`=1 and zeroes on each edge with `s`=0. It is held at 0 in every other state.
- `fault` = ARMED and `s`=1 and the filter counter = FILTER_LEN−1, i.e. the FILTER_LEN-th consecutive high sample.
- Retry counter: range 0..MAX_RETRIES, reset only by reset or `clear`.

States:
- ARMED: bias on.
  - On `fault` with retry < MAX_RETRIES: go to COOLDOWN, retry += 1.
  - On `fault` with retry = MAX_RETRIES: go to LOCKOUT.
- COOLDOWN: bias off. The timer loads COOLDOWN_CYCLES−1 on entry and decrements each cycle. At 0 the block returns to ARMED unconditionally; a comparator that is still high re-trips through the filter.
- LOCKOUT: bias off. The only exit is `clear` while `s`=0, which goes to ARMED. A `clear` with `s`=1 still clears the flag and counters but the block stays in LOCKOUT.

On every trip:
- `overcurrent` is set.
- `trip_count` increments and saturates at 2^CNT_W−1.

`clear` effects:
- Zeroes `overcurrent`, `trip_count` and the retry counter in any state.
- In COOLDOWN the timer continues unaffected.

Simultaneous `fault` and `clear` in ARMED: the fault wins. The trip is taken, `overcurrent` = 1, `trip_count` = 1 and retry = 1.

Outputs are all registered:
- `bias_en` next value = (next_state == ARMED).
- `lockout` next value = (next_state == LOCKOUT).

Reset (async, reset_n low):
- State ARMED.
- All counters 0.
- `bias_en`=0, `overcurrent`=0, `lockout`=0, `trip_count`=0.
- Synchronizer flops 0.

## Timing
- Trip latency: with `comp_in` high and stable before edge E0, the trip registers at edge E0+SYNC_STAGES+FILTER_LEN−1. `bias_en` falls and `overcurrent` and `trip_count` update at that same edge.
- A high pulse shorter than FILTER_LEN synchronized samples never trips and leaves no state change.
- COOLDOWN entered at edge T: `bias_en` returns to 1 at edge T+COOLDOWN_CYCLES.
- `clear` takes effect at the edge that samples it; outputs change one register later than the pulse.
- Exit from LOCKOUT: `bias_en` = 1 at the edge sampling `clear`.
- First edge after reset release: `bias_en` goes to 1.
- Reset asserted mid-COOLDOWN or mid-LOCKOUT: outputs go to reset values immediately, asynchronously; all history is lost.

## Test plan
Bench parameters: SYNC_STAGES=2, FILTER_LEN=4, COOLDOWN_CYCLES=10, MAX_RETRIES=2, CNT_W=8.

1. Release reset, `comp_in`=0 → `bias_en`=1 after the first edge; `overcurrent`=0, `trip_count`=0, `lockout`=0.
2. Glitches: `comp_in` high for 3 cycles, then low, repeated 5 times → no trip; `bias_en` stays 1, `trip_count`=0.
3. `comp_in` high from E0 for 4 cycles → at edge E0+5: `bias_en`=0, `overcurrent`=1, `trip_count`=1. At edge E0+15: `bias_en`=1.
4. `comp_in` held high permanently → trips at 1, 2 and 3 with cooldowns between; after the 3rd trip `lockout`=1, `bias_en` stays 0, `trip_count`=3.
5. From lockout:
   - `clear` with `comp_in` high → `overcurrent`=0, `trip_count`=0, `lockout` stays 1.
   - Drop `comp_in`, wait 3 cycles, `clear` → `lockout`=0, `bias_en`=1.
6. `clear` pulsed on the exact `fault` edge → `overcurrent`=1, `trip_count`=1. Then assert reset_n low mid-COOLDOWN → all outputs 0 asynchronously, and `bias_en`=1 one edge after release.
